// File: rtl/lrelu_pkg.sv
// Shared definitions for the LReLU config/data sequencer.
// State encoding and kw2 field defaults shared with the engine.
package lrelu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  localparam int I_KW2_DEF    = 0;
  localparam int BITS_KW2_DEF = 3;

endpackage

// File: rtl/axis_lrelu_config_sequencer_if.sv
// AXI-Stream style bundle used for cfg, data and engine ports.
// Master drives payload and valid, slave drives ready.
interface axis_lrelu_config_sequencer_if #(
  parameter int DW = 512,
  parameter int UW = 8
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0] tuser;
  logic          tlast;

  modport master (
    output tvalid, tdata, tkeep, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/lrelu_seq_downcounter.sv
// Loadable down-counter that saturates at zero.
// Load wins over decrement; is_zero reflects the registered value.
module lrelu_seq_downcounter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         is_zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: load, else decrement only when nonzero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/axis_lrelu_config_sequencer.sv
// Interleaves config bursts and data iterations into the LReLU engine.
// Optional sticky error checker: define LRELU_SEQ_ERR_EN.
module axis_lrelu_config_sequencer
  import lrelu_pkg::*;
#(
  parameter int TDATA_WIDTH  = 512,
  parameter int TUSER_WIDTH  = 8,
  parameter int I_KW2        = I_KW2_DEF,
  parameter int BITS_KW2     = BITS_KW2_DEF,
  parameter int CFG_BEATS_K1 = 2,
  parameter int CFG_BEATS_KN = 4,
  parameter int ITER_BITS    = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 s_iter_tvalid,
  output logic                 s_iter_tready,
  input  logic [ITER_BITS-1:0] s_iter_tdata,
  axis_lrelu_config_sequencer_if.slave  s_cfg,
  axis_lrelu_config_sequencer_if.slave  s_dat,
  axis_lrelu_config_sequencer_if.master m_axis,
  output logic                 layer_done,
  output logic [1:0]           state,
  output logic [1:0]           err
);

  localparam int BEAT_BITS = 8;
  localparam logic [BEAT_BITS-1:0] LOAD_K1 =
    (CFG_BEATS_K1 >= 2) ? BEAT_BITS'(CFG_BEATS_K1 - 2) : '0;
  localparam logic [BEAT_BITS-1:0] LOAD_KN =
    (CFG_BEATS_KN >= 2) ? BEAT_BITS'(CFG_BEATS_KN - 2) : '0;
  localparam logic ONE_K1 = (CFG_BEATS_K1 <= 1);
  localparam logic ONE_KN = (CFG_BEATS_KN <= 1);

  seq_state_e state_q;
  logic       first_q;
  logic       done_q;

  logic [TUSER_WIDTH-1:0] cfg_user;
  logic [BITS_KW2-1:0]    kw2;
  logic                   kw2_zero;
  logic                   iter_hs;
  logic                   cfg_hs;
  logic                   dat_hs;
  logic                   cfg_one;
  logic                   cfg_end;
  logic                   iter_zero;
  logic                   beat_zero;
  logic [BEAT_BITS-1:0]   beat_load;
  logic                   unused_cfg;

  assign cfg_user   = s_cfg.tuser;
  assign kw2        = cfg_user[I_KW2 +: BITS_KW2];
  assign kw2_zero   = (kw2 == '0);
  assign unused_cfg = ^{s_cfg.tkeep, s_cfg.tlast};

  assign iter_hs = (state_q == ST_IDLE) && s_iter_tvalid;
  assign cfg_hs  = (state_q == ST_CFG) && s_cfg.tvalid && m_axis.tready;
  assign dat_hs  = (state_q == ST_DATA) && s_dat.tvalid && m_axis.tready;

  assign beat_load = kw2_zero ? LOAD_K1 : LOAD_KN;
  assign cfg_one   = kw2_zero ? ONE_K1 : ONE_KN;
  assign cfg_end   = cfg_hs && (first_q ? cfg_one : beat_zero);

  // per-layer iteration count, loaded from the layer command
  lrelu_seq_downcounter #(.W(ITER_BITS)) u_iter_cnt (
    .clk        (aclk),
    .rst        (areset),
    .load_i     (iter_hs),
    .load_val_i (s_iter_tdata),
    .dec_i      (dat_hs && s_dat.tlast),
    .is_zero_o  (iter_zero)
  );

  // remaining config beats after the first of each burst
  lrelu_seq_downcounter #(.W(BEAT_BITS)) u_beat_cnt (
    .clk        (aclk),
    .rst        (areset),
    .load_i     (cfg_hs && first_q),
    .load_val_i (beat_load),
    .dec_i      (cfg_hs && !first_q),
    .is_zero_o  (beat_zero)
  );

  // source select driven purely by registered state
  always_comb begin
    s_iter_tready = (state_q == ST_IDLE);
    s_cfg.tready  = 1'b0;
    s_dat.tready  = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = s_cfg.tdata;
    m_axis.tkeep  = {(TDATA_WIDTH/8){1'b1}};
    m_axis.tuser  = s_cfg.tuser;
    m_axis.tlast  = 1'b0;
    unique case (state_q)
      ST_CFG: begin
        m_axis.tvalid = s_cfg.tvalid;
        s_cfg.tready  = m_axis.tready;
      end
      ST_DATA: begin
        m_axis.tvalid = s_dat.tvalid;
        m_axis.tdata  = s_dat.tdata;
        m_axis.tkeep  = s_dat.tkeep;
        m_axis.tuser  = s_dat.tuser;
        m_axis.tlast  = s_dat.tlast;
        s_dat.tready  = m_axis.tready;
      end
      default: ;
    endcase
  end

  // sequencing FSM with registered done pulse
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (iter_hs) begin
            state_q <= ST_CFG;
            first_q <= 1'b1;
          end
        end
        ST_CFG: begin
          if (cfg_hs) begin
            first_q <= 1'b0;
            if (cfg_end) state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (dat_hs && s_dat.tlast) begin
            if (iter_zero) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_CFG;
              first_q <= 1'b1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
      endcase
    end
  end

  assign layer_done = done_q;
  assign state      = state_q;

`ifdef LRELU_SEQ_ERR_EN
  localparam logic [BITS_KW2-1:0] KW2_MAX =
    BITS_KW2'((1 << BITS_KW2) - 2);

  logic [1:0] err_q;

  // sticky protocol errors, cleared only by reset
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_q <= '0;
    end else begin
      if (cfg_hs && first_q && kw2 > KW2_MAX) err_q[0] <= 1'b1;
      if (dat_hs && !s_dat.tlast && s_dat.tkeep != '1)
        err_q[1] <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 2'b00;
`endif

endmodule

// File: tb/tb_axis_lrelu_config_sequencer.sv
// Directed bench for axis_lrelu_config_sequencer.
// Two instances: default burst lengths and a 1-beat 1x1 burst.
module tb_axis_lrelu_config_sequencer;

  localparam int DW = 32;

`ifdef LRELU_SEQ_ERR_EN
  localparam logic [1:0] ERR_FINAL = 2'b11;
`else
  localparam logic [1:0] ERR_FINAL = 2'b00;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [7:0]  u;
    logic        l;
  } beat_t;

  logic        aclk;
  logic        areset;
  logic        it_v;
  logic        it_rdy;
  logic [15:0] it_d;
  logic        done;
  logic [1:0]  st;
  logic [1:0]  err;

  logic        it1_v;
  logic        it1_rdy;
  logic [15:0] it1_d;
  logic        done1;
  logic [1:0]  st1;
  logic [1:0]  err1;

  axis_lrelu_config_sequencer_if #(.DW(DW), .UW(8)) cfg_if ();
  axis_lrelu_config_sequencer_if #(.DW(DW), .UW(8)) dat_if ();
  axis_lrelu_config_sequencer_if #(.DW(DW), .UW(8)) m_if ();
  axis_lrelu_config_sequencer_if #(.DW(DW), .UW(8)) c1_if ();
  axis_lrelu_config_sequencer_if #(.DW(DW), .UW(8)) d1_if ();
  axis_lrelu_config_sequencer_if #(.DW(DW), .UW(8)) m1_if ();

  axis_lrelu_config_sequencer #(.TDATA_WIDTH(DW)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_iter_tvalid (it_v),
    .s_iter_tready (it_rdy),
    .s_iter_tdata  (it_d),
    .s_cfg         (cfg_if),
    .s_dat         (dat_if),
    .m_axis        (m_if),
    .layer_done    (done),
    .state         (st),
    .err           (err)
  );

  axis_lrelu_config_sequencer #(
    .TDATA_WIDTH(DW), .CFG_BEATS_K1(1)
  ) dut1 (
    .aclk          (aclk),
    .areset        (areset),
    .s_iter_tvalid (it1_v),
    .s_iter_tready (it1_rdy),
    .s_iter_tdata  (it1_d),
    .s_cfg         (c1_if),
    .s_dat         (d1_if),
    .m_axis        (m1_if),
    .layer_done    (done1),
    .state         (st1),
    .err           (err1)
  );

  int    n_chk;
  int    n_fail;
  int    viol;
  int    seq;
  logic  rnd_rdy;
  logic  cfg_fire;
  logic  dat_fire;
  beat_t cfg_q[$];
  beat_t dat_q[$];
  beat_t exp_q[$];
  beat_t log_q[$];

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // capture transfers and cfg-phase data-ready leaks
  always @(negedge aclk) begin
    cfg_fire = cfg_if.tvalid && cfg_if.tready;
    dat_fire = dat_if.tvalid && dat_if.tready;
    if (m_if.tvalid && m_if.tready)
      log_q.push_back({m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast});
    if (st == 2'd1 && dat_if.tready) viol++;
  end

  // source feeders and sink ready
  always @(posedge aclk) begin
    #1;
    if (cfg_fire && cfg_q.size() > 0) void'(cfg_q.pop_front());
    if (dat_fire && dat_q.size() > 0) void'(dat_q.pop_front());
    cfg_if.tvalid = (cfg_q.size() > 0);
    if (cfg_q.size() > 0) begin
      cfg_if.tdata = cfg_q[0].d;
      cfg_if.tuser = cfg_q[0].u;
    end
    dat_if.tvalid = (dat_q.size() > 0);
    if (dat_q.size() > 0) begin
      dat_if.tdata = dat_q[0].d;
      dat_if.tkeep = dat_q[0].k;
      dat_if.tuser = dat_q[0].u;
      dat_if.tlast = dat_q[0].l;
    end
    m_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic add_layer(input int iters, input int kw2,
                           input int dlen);
    int clen;
    beat_t b;
    clen = (kw2 == 0) ? 2 : 4;
    for (int it = 0; it <= iters; it++) begin
      for (int c = 0; c < clen; c++) begin
        seq++;
        b = '{d: 32'hC000_0000 + 32'(seq), k: 4'h0, u: 8'(kw2), l: 1'b1};
        cfg_q.push_back(b);
        b.k = 4'hF;
        b.l = 1'b0;
        exp_q.push_back(b);
      end
      for (int j = 0; j < dlen; j++) begin
        seq++;
        b = '{d: 32'hD000_0000 + 32'(seq), k: 4'hF, u: 8'h5A,
              l: (j == dlen - 1)};
        dat_q.push_back(b);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic issue(input logic [15:0] n);
    @(posedge aclk);
    #2;
    it_v = 1'b1;
    it_d = n;
    @(negedge aclk);
    chk("iter_rdy", it_rdy, 1);
    @(posedge aclk);
    #2;
    it_v = 1'b0;
  endtask

  task automatic run_layer(input string nm, input int iters,
                           input int nlast);
    int dn;
    int post;
    int lasts;
    log_q.delete();
    issue(16'(iters));
    dn = 0;
    post = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge aclk);
      if (done) dn++;
      if (dn > 0) post++;
      if (post == 4) break;
    end
    chk({nm, "_nbeats"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_beat%0d", nm, i), log_q[i], exp_q[i]);
    lasts = 0;
    foreach (log_q[i]) if (log_q[i].l) lasts++;
    chk({nm, "_tlasts"}, lasts, nlast);
    chk({nm, "_done_pulse"}, dn, 1);
    chk({nm, "_state_idle"}, st, 0);
    exp_q.delete();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    viol = 0;
    seq = 0;
    rnd_rdy = 1'b0;
    cfg_fire = 1'b0;
    dat_fire = 1'b0;
    areset = 1'b1;
    it_v = 1'b0;
    it_d = '0;
    it1_v = 1'b0;
    it1_d = '0;
    cfg_if.tvalid = 1'b0;
    cfg_if.tdata = '0;
    cfg_if.tuser = '0;
    cfg_if.tkeep = 4'h0;
    cfg_if.tlast = 1'b1;
    dat_if.tvalid = 1'b0;
    dat_if.tdata = '0;
    dat_if.tkeep = '0;
    dat_if.tuser = '0;
    dat_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    c1_if.tvalid = 1'b0;
    c1_if.tdata = '0;
    c1_if.tuser = '0;
    c1_if.tkeep = '0;
    c1_if.tlast = 1'b0;
    d1_if.tvalid = 1'b0;
    d1_if.tdata = '0;
    d1_if.tkeep = '0;
    d1_if.tuser = '0;
    d1_if.tlast = 1'b0;
    m1_if.tready = 1'b0;

    repeat (2) @(negedge aclk);
    chk("rst_state", st, 0);
    chk("rst_mvalid", m_if.tvalid, 0);
    chk("rst_iter_rdy", it_rdy, 1);
    chk("rst_cfg_rdy", cfg_if.tready, 0);
    chk("rst_dat_rdy", dat_if.tready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge aclk);
    #2;
    areset = 1'b0;

    add_layer(0, 0, 4);
    run_layer("k1_single", 0, 1);

    add_layer(2, 1, 3);
    run_layer("kn_three", 2, 3);
    chk("cfg_dat_rdy_leak", viol, 0);

    rnd_rdy = 1'b1;
    add_layer(3, 2, 2);
    run_layer("rand_rdy", 3, 4);
    rnd_rdy = 1'b0;
    chk("rand_dat_rdy_leak", viol, 0);
    chk("err_clean", err, 0);

    // abort in DATA after two data beats
    log_q.delete();
    add_layer(0, 0, 4);
    issue(16'd0);
    for (int c = 0; c < 50 && log_q.size() < 4; c++) @(negedge aclk);
    chk("abort_reached", log_q.size(), 4);
    @(posedge aclk);
    #2;
    chk("abort_in_data", st, 2);
    areset = 1'b1;
    cfg_q.delete();
    dat_q.delete();
    exp_q.delete();
    #1;
    chk("abort_state", st, 0);
    chk("abort_mvalid", m_if.tvalid, 0);
    chk("abort_iter_rdy", it_rdy, 1);
    @(posedge aclk);
    #2;
    areset = 1'b0;
    add_layer(0, 0, 4);
    run_layer("after_abort", 0, 1);

    // single-beat 1x1 burst instance
    @(posedge aclk);
    #2;
    m1_if.tready = 1'b1;
    it1_v = 1'b1;
    it1_d = 16'd0;
    @(negedge aclk);
    chk("b1_iter_rdy", it1_rdy, 1);
    @(posedge aclk);
    #2;
    it1_v = 1'b0;
    c1_if.tvalid = 1'b1;
    c1_if.tdata = 32'h0000_00AB;
    c1_if.tuser = 8'h00;
    @(negedge aclk);
    chk("b1_state_cfg", st1, 1);
    chk("b1_cfg_rdy", c1_if.tready, 1);
    chk("b1_m_cfg", m1_if.tdata, 32'h0000_00AB);
    chk("b1_dat_rdy_cfg", d1_if.tready, 0);
    @(posedge aclk);
    #2;
    c1_if.tvalid = 1'b0;
    d1_if.tvalid = 1'b1;
    d1_if.tdata = 32'h0000_00CD;
    d1_if.tkeep = 4'hF;
    d1_if.tlast = 1'b1;
    @(negedge aclk);
    chk("b1_state_data", st1, 2);
    chk("b1_dat_rdy", d1_if.tready, 1);
    chk("b1_m_dat", {m1_if.tvalid, m1_if.tlast, m1_if.tdata},
        {2'b11, 32'h0000_00CD});
    @(posedge aclk);
    #2;
    d1_if.tvalid = 1'b0;
    @(negedge aclk);
    chk("b1_done", {st1, done1}, {2'd3, 1'b1});
    @(negedge aclk);
    chk("b1_idle", {st1, done1}, {2'd0, 1'b0});

    // bad kw2 and partial keep mid-iteration
    add_layer(0, 7, 4);
    dat_q[1].k = 4'h3;
    exp_q[5].k = 4'h3;
    run_layer("err_layer", 0, 1);
    chk("err_final", err, ERR_FINAL);
    repeat (3) @(negedge aclk);
    chk("err_held", err, ERR_FINAL);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_lrelu_config_sequencer.md
# axis_lrelu_config_sequencer

Sequences the single slave port of the LReLU engine between a config stream and the conv-output data stream. Per layer, it interleaves one config burst and one data iteration at a time, N times, then signals completion. The config burst length is selected by the kw2 field. The block sits between the conv core / config DMA and the LReLU engine input, and guarantees config beats never carry tlast.

## Interface
- TDATA_WIDTH, 512, data/config bus width (bits)
- TUSER_WIDTH, 8, tuser width on all streams
- I_KW2, 0, bit index of kw2 field in s_cfg_tuser
- BITS_KW2, 3, kw2 field width
- CFG_BEATS_K1, 2, config beats when kw2==0 (1x1)
- CFG_BEATS_KN, 4, config beats when kw2!=0
- ITER_BITS, 16, iteration counter width

- aclk  in  1  clock
- areset  in  1  reset; async assert, active-high
- s_iter_tvalid / s_iter_tready  in/out  1  per-layer command handshake
- s_iter_tdata  in  ITER_BITS  iterations-1 for the layer
- s_cfg_tvalid / s_cfg_tready  in/out  1  config stream
- s_cfg_tdata  in  TDATA_WIDTH  config beat
- s_cfg_tuser  in  TUSER_WIDTH  carries kw2
- s_dat_tvalid / s_dat_tready  in/out  1  conv data stream
- s_dat_tdata  in  TDATA_WIDTH  data
- s_dat_tkeep  in  TDATA_WIDTH/8  byte keep
- s_dat_tuser  in  TUSER_WIDTH  user
- s_dat_tlast  in  1  end of iteration
- m_axis_tvalid / m_axis_tready  out/in  1  to engine
- m_axis_tdata / m_axis_tkeep / m_axis_tuser / m_axis_tlast  out  as above  muxed beat
- layer_done  out  1  one-cycle pulse after the final iteration's tlast
- state  out  2  current state, for debug_config
- err  out  2  sticky protocol errors

## Operation
- States: IDLE=0, CFG=1, DATA=2, DONE=3.
- IDLE: s_iter_tready=1.
  - On s_iter handshake: iter_cnt <= s_iter_tdata; first <= 1; go to CFG.
- CFG: m_axis_* are driven from s_cfg_*. m_axis_tkeep is all ones. m_axis_tlast is forced 0. s_dat_tready=0.
  - First handshake (first=1): beat_cnt <= (kw2==0 ? CFG_BEATS_K1 : CFG_BEATS_KN) - 2.
  - If the burst length is 1, go to DATA on that same handshake.
  - Later handshakes: if beat_cnt==0, go to DATA; otherwise decrement beat_cnt.
  - first clears on the first handshake.
- DATA: m_axis_* are driven from s_dat_*. s_cfg_tready=0.
  - On a handshake with tlast: if iter_cnt==0, go to DONE. Otherwise decrement iter_cnt, set first<=1, go to CFG.
- DONE: layer_done=1 for one cycle; go to IDLE.
- The unselected source always sees tready=0. In IDLE and DONE, m_axis_tvalid=0.
- Reset values: state=IDLE, iter_cnt=0, beat_cnt=0, first=0, err=0. m_axis_tvalid=0, all s_*_tready=0 except s_iter_tready=1 (IDLE), layer_done=0.
- areset asserted mid-layer: abort immediately to IDLE. No beat is completed partially. Upstream is responsible for flushing.
- Counter arithmetic is unsigned and never wraps. Decrement occurs only when the value is nonzero.

## Timing
- Zero-latency combinational mux: m_axis_tvalid = selected s_tvalid, and selected s_tready = m_axis_tready.
- The select is registered state only. There is no combinational path from any tvalid to a select change.
- The state change takes effect on the clock edge after the qualifying handshake. The next beat from the new source can transfer in the very next cycle.
- A new layer command is accepted in the cycle after DONE, giving a minimum 2-cycle gap between layers.
- s_iter_tdata=0 means exactly one config+data iteration.

## Configuration
- LRELU_SEQ_ERR_EN defined, err is sticky until areset:
  - err[0] sets when the first config beat carries kw2 > 2**BITS_KW2-2.
  - err[1] sets on a DATA handshake with tlast=0 and tkeep not all ones.
- LRELU_SEQ_ERR_EN undefined: err is tied to 0 and no checker logic is synthesised.

## Structure
- Shared package (lrelu_pkg): state encoding localparams, and the I_KW2/BITS_KW2 defaults that are shared with the engine.
- One sub-module: lrelu_seq_downcounter (load, dec-enable, is_zero; width parameter). It is instantiated twice, for iter_cnt and beat_cnt.

## Test plan
- iters=0, kw2=0: 2 config beats, then 4 data beats with tlast on the 4th -> m sees 6 beats with m_tlast only on beat 6; layer_done pulses one cycle later; state returns to 0.
- iters=2, kw2=1: 3×(4 cfg + 3 data) -> 21 m beats; 3 tlasts; s_dat_tready=0 throughout every CFG phase.
- m_axis_tready toggled randomly with both sources always valid -> no beat is lost or duplicated; config tlast never seen; order matches the model.
- CFG_BEATS_K1=1, kw2=0 -> state goes to DATA on the first cfg handshake; the next cycle accepts data.
- areset asserted in DATA after 2 beats -> next cycle state=0, m_axis_tvalid=0, s_iter_tready=1; the new layer proceeds normally.
- With LRELU_SEQ_ERR_EN: kw2=7, BITS_KW2=3 -> err[0]=1 and held; a mid-iteration beat with tkeep=0x0F… -> err[1]=1.
